// File: rtl/rggen_bit_field_rs_lease_pkg.sv
// Shared types and index helpers for the RS bit-field lease controller.
package rggen_bit_field_rs_lease_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    EXPIRE
  } lease_state_e;

  function automatic int calc_index_width(int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  function automatic int wrap_inc(int index, int width);
    return (index + 1 >= width) ? 0 : index + 1;
  endfunction

endpackage

// File: rtl/rggen_round_robin_picker.sv
// Finds the first set request at or above the pointer, wrapping around.
module rggen_round_robin_picker
  import rggen_bit_field_rs_lease_pkg::*;
#(
  parameter  int WIDTH       = 8,
  localparam int INDEX_WIDTH = calc_index_width(WIDTH)
)(
  input  logic [WIDTH-1:0]       i_request,
  input  logic [INDEX_WIDTH-1:0] i_pointer,
  output logic                   o_found,
  output logic [INDEX_WIDTH-1:0] o_index
);

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    logic [INDEX_WIDTH-1:0] slot;
    slot    = '0;
    o_found = 1'b0;
    o_index = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      slot = INDEX_WIDTH'((int'(i_pointer) + k) % WIDTH);
      if (i_request[slot]) begin
        o_found = 1'b1;
        o_index = slot;
      end
    end
  end

endmodule

// File: rtl/rggen_bit_field_rs_lease_ctrl.sv
// Lease controller for a read-to-set bit field: times each claimed bit and
// clears it on expiry or on a hardware release request.
module rggen_bit_field_rs_lease_ctrl
  import rggen_bit_field_rs_lease_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int TIMER_WIDTH = 16,
  parameter int INDEX_WIDTH = calc_index_width(WIDTH)
)(
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic [TIMER_WIDTH-1:0] i_lease_cycles,
  input  logic [WIDTH-1:0]       i_value,
  input  logic [WIDTH-1:0]       i_release,
  output logic [WIDTH-1:0]       o_clear,
  output logic [WIDTH-1:0]       o_expired,
  output logic                   o_busy,
  output logic [INDEX_WIDTH-1:0] o_active_index
);

  lease_state_e           state;
  lease_state_e           state_next;
  logic [TIMER_WIDTH-1:0] count;
  logic [TIMER_WIDTH-1:0] count_next;
  logic [INDEX_WIDTH-1:0] pointer;
  logic [INDEX_WIDTH-1:0] pointer_next;
  logic [INDEX_WIDTH-1:0] index_next;
  logic [INDEX_WIDTH-1:0] index_inc;
  logic [WIDTH-1:0]       cand;
  logic [WIDTH-1:0]       expire_next;
  logic                   pick_found;
  logic [INDEX_WIDTH-1:0] pick_index;

  // A bit already being cleared this cycle must not start a new lease.
  assign cand      = i_value & ~i_release & ~o_clear;
  assign index_inc = INDEX_WIDTH'(wrap_inc(int'(o_active_index), WIDTH));
  assign o_busy    = (state != IDLE);

  rggen_round_robin_picker #(
    .WIDTH (WIDTH)
  ) u_picker (
    .i_request (cand),
    .i_pointer (pointer),
    .o_found   (pick_found),
    .o_index   (pick_index)
  );

  always_comb begin
    state_next   = state;
    count_next   = count;
    pointer_next = pointer;
    index_next   = o_active_index;
    expire_next  = '0;
    case (state)
      IDLE: begin
        if (i_enable && pick_found) begin
          index_next = pick_index;
          count_next = (i_lease_cycles == '0) ? TIMER_WIDTH'(1) : i_lease_cycles;
          state_next = COUNT;
        end
      end
      COUNT: begin
        if (!i_enable || !i_value[o_active_index] || i_release[o_active_index]) begin
          state_next   = IDLE;
          pointer_next = index_inc;
          index_next   = '0;
        end else if (count == TIMER_WIDTH'(1)) begin
          state_next                  = EXPIRE;
          expire_next[o_active_index] = 1'b1;
        end else begin
          count_next = count - TIMER_WIDTH'(1);
        end
      end
      EXPIRE: begin
        state_next   = IDLE;
        pointer_next = index_inc;
        index_next   = '0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      count          <= '0;
      pointer        <= '0;
      o_active_index <= '0;
      o_clear        <= '0;
      o_expired      <= '0;
    end else begin
      state          <= state_next;
      count          <= count_next;
      pointer        <= pointer_next;
      o_active_index <= index_next;
      o_clear        <= (i_value & i_release) | expire_next;
      o_expired      <= expire_next;
    end
  end

endmodule

// File: tb/tb_rggen_bit_field_rs_lease_ctrl.sv
// Self-checking bench for the RS lease controller with an RS field model.
module tb_rggen_bit_field_rs_lease_ctrl;

  localparam int W  = 8;
  localparam int TW = 16;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [TW-1:0] lease;
  logic [W-1:0]  rs_value;
  logic [W-1:0]  rel;
  logic [W-1:0]  clear;
  logic [W-1:0]  expired;
  logic          busy;
  logic [IW-1:0] aidx;
  logic [W-1:0]  sw_set;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: one lease record plus a fairness pointer.
  bit           m_busy, m_expiring;
  int           m_idx, m_left, m_ptr;
  logic [W-1:0] m_clear, m_exp;
  bit           n_busy, n_expiring;
  int           n_idx, n_left, n_ptr;
  logic [W-1:0] n_clear, n_exp;

  always #5 clk = ~clk;

  rggen_bit_field_rs_lease_ctrl #(
    .WIDTH       (W),
    .TIMER_WIDTH (TW)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_enable       (en),
    .i_lease_cycles (lease),
    .i_value        (rs_value),
    .i_release      (rel),
    .o_clear        (clear),
    .o_expired      (expired),
    .o_busy         (busy),
    .o_active_index (aidx)
  );

  task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_next();
    logic [W-1:0] cand;
    if (!rst_n) begin
      n_busy = 0; n_expiring = 0; n_idx = 0; n_left = 0; n_ptr = 0;
      n_clear = '0; n_exp = '0;
    end else begin
      n_busy = m_busy; n_expiring = 0; n_idx = m_idx; n_left = m_left; n_ptr = m_ptr;
      n_clear = rs_value & rel;
      n_exp   = '0;
      if (!m_busy) begin
        cand = rs_value & ~rel & ~m_clear;
        if (en && cand != '0) begin
          for (int k = 0; k < W; k++) begin
            int j;
            j = (m_ptr + k) % W;
            if (cand[j]) begin
              n_busy = 1;
              n_idx  = j;
              n_left = (lease == 0) ? 1 : int'(lease);
              break;
            end
          end
        end
      end else if (m_expiring) begin
        n_busy = 0; n_idx = 0; n_ptr = (m_idx + 1) % W;
      end else if (!en || !rs_value[m_idx] || rel[m_idx]) begin
        n_busy = 0; n_idx = 0; n_ptr = (m_idx + 1) % W;
      end else if (m_left == 1) begin
        n_expiring     = 1;
        n_clear[m_idx] = 1'b1;
        n_exp[m_idx]   = 1'b1;
      end else begin
        n_left = m_left - 1;
      end
    end
  endtask

  task automatic compare();
    check_val("clear",   32'(clear),   32'(m_clear));
    check_val("expired", 32'(expired), 32'(m_exp));
    check_val("busy",    32'(busy),    32'(m_busy));
    check_val("index",   32'(aidx),    32'(m_idx));
  endtask

  // One clock: model sees the same inputs, RS field applies set-over-clear.
  task automatic tick();
    model_next();
    @(posedge clk);
    #1;
    rs_value = sw_set | (rs_value & ~m_clear);
    m_busy = n_busy; m_expiring = n_expiring; m_idx = n_idx;
    m_left = n_left; m_ptr = n_ptr; m_clear = n_clear; m_exp = n_exp;
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic do_reset();
    rst_n = 0; rs_value = '0; rel = '0; sw_set = '0; en = 1;
    tick();
    tick();
    rst_n = 1;
    cyc = 0;
  endtask

  initial begin
    rst_n = 0; en = 1; lease = 16'd4; rel = '0; sw_set = '0; rs_value = '0;
    m_busy = 0; m_expiring = 0; m_idx = 0; m_left = 0; m_ptr = 0;
    m_clear = '0; m_exp = '0;
    @(negedge clk);

    // Basic lease on bit 2, L=4
    do_reset();
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_clear", 32'(clear), 32'd0);
    lease = 16'd4; rs_value = 8'h04;
    tick();
    check_val("t1_busy_c1", 32'(busy), 32'd1);
    check_val("t1_idx_c1", 32'(aidx), 32'd2);
    repeat (3) tick();
    check_val("t1_clear_c4", 32'(clear), 32'h00);
    tick();
    check_val("t1_clear_c5", 32'(clear), 32'h04);
    check_val("t1_exp_c5", 32'(expired), 32'h04);
    tick();
    check_val("t1_clear_c6", 32'(clear), 32'h00);
    check_val("t1_exp_c6", 32'(expired), 32'h00);

    // Round-robin with wrap
    do_reset();
    lease = 16'd2; rs_value = 8'h81;
    repeat (3) tick();
    check_val("t2_clear_c3", 32'(clear), 32'h01);
    repeat (4) tick();
    check_val("t2_clear_c7", 32'(clear), 32'h80);
    tick();
    check_val("t2_busy_c8", 32'(busy), 32'd0);
    rs_value = 8'h81;
    tick();
    check_val("t2_wrap_idx", 32'(aidx), 32'd0);
    check_val("t2_wrap_busy", 32'(busy), 32'd1);

    // Early release aborts without expiry
    do_reset();
    lease = 16'd10; rs_value = 8'h08;
    repeat (4) tick();
    rel = 8'h08;
    tick();
    check_val("t3_clear_c5", 32'(clear), 32'h08);
    check_val("t3_exp_c5", 32'(expired), 32'h00);
    check_val("t3_busy_c5", 32'(busy), 32'd0);
    rel = '0;
    tick();
    check_val("t3_busy_c6", 32'(busy), 32'd0);

    // Zero lease length acts as one
    do_reset();
    lease = 16'd0; rs_value = 8'h01;
    tick();
    check_val("t4_busy_c1", 32'(busy), 32'd1);
    tick();
    check_val("t4_clear_c2", 32'(clear), 32'h01);
    check_val("t4_exp_c2", 32'(expired), 32'h01);

    // Enable drop aborts; release still works while disabled
    do_reset();
    lease = 16'd8; rs_value = 8'h10;
    repeat (3) tick();
    en = 0;
    tick();
    check_val("t5_busy_c4", 32'(busy), 32'd0);
    check_val("t5_clear_c4", 32'(clear), 32'h00);
    rel = 8'h10;
    tick();
    check_val("t5_rel_clear", 32'(clear), 32'h10);
    rel = '0; en = 1;
    tick();

    // Reset mid-lease, then pointer restarts at 0
    do_reset();
    lease = 16'd1; rs_value = 8'h02;
    repeat (3) tick();
    check_val("t6_busy_c3", 32'(busy), 32'd0);
    rs_value = 8'h21; lease = 16'd8;
    repeat (2) tick();
    check_val("t6_idx_pre", 32'(aidx), 32'd5);
    rst_n = 0;
    tick();
    check_val("t6_rst_busy", 32'(busy), 32'd0);
    check_val("t6_rst_clear", 32'(clear), 32'h00);
    check_val("t6_rst_idx", 32'(aidx), 32'd0);
    rst_n = 1;
    tick();
    check_val("t6_restart_busy", 32'(busy), 32'd1);
    check_val("t6_restart_idx", 32'(aidx), 32'd0);

    // Randomized traffic against the model
    do_reset();
    repeat (4000) begin
      en     = ($urandom_range(0, 15) != 0);
      lease  = 16'($urandom_range(0, 6));
      rel    = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom & $urandom) : 8'h00;
      sw_set = 8'($urandom & $urandom);
      rst_n  = ($urandom_range(0, 499) != 0);
      tick();
    end
    sw_set = '0; rel = '0; rst_n = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
